// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: packs decoded RV32I fields (format, opcode, registers,
// funct fields, full 32-bit immediate) into an instruction word. Each word
// gets a sequential byte address and a range-check flag. The single output
// register stage uses a valid/ready handshake.
module rv_instr_encoder #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int                ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           fmt,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [ADDR_W-1:0] addr_cnt;
  logic [31:0]       enc_instr;
  logic              enc_err;
  logic              accept;

  // Sign-extension checks: the bits above the encodable field must all
  // replicate its sign bit.
  logic ext_12;
  logic ext_13;
  logic ext_21;

  assign ext_12 = (&imm[31:11]) || !(|imm[31:11]);
  assign ext_13 = (&imm[31:12]) || !(|imm[31:12]);
  assign ext_21 = (&imm[31:20]) || !(|imm[31:20]);

  // A stalled output frees up the moment the consumer takes it.
  assign in_ready = !out_valid || out_ready;

  // clear beats a simultaneous accept, so the bundle is dropped.
  assign accept = in_valid && in_ready && !clear;

  // Field placement and range check for the presented bundle.
  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    case (fmt)
      FMT_R: begin
        enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err   = !ext_12;
      end
      FMT_S: begin
        enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err   = !ext_12;
      end
      FMT_B: begin
        enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err   = !ext_13 || imm[0];
      end
      FMT_U: begin
        enc_instr = {imm[31:12], rd, opcode};
        enc_err   = |imm[11:0];
      end
      FMT_J: begin
        enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err   = !ext_21 || imm[0];
      end
      default: begin
        // Illegal format: emit an all-zero word flagged as an error.
        enc_instr = '0;
        enc_err   = 1'b1;
      end
    endcase
  end

  // Output register, address counter and saturating error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      out_addr  <= START_ADDR;
      addr_cnt  <= START_ADDR;
      err_count <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      addr_cnt  <= START_ADDR;
      err_count <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_instr <= enc_instr;
      out_err   <= enc_err;
      out_addr  <= addr_cnt;
      addr_cnt  <= addr_cnt + ADDR_W'(4);
      if (enc_err && !(&err_count)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Testbench for rv_instr_encoder: scoreboard-checked random and directed
// traffic on a default instance, plus a narrow-address instance for wrap,
// clear and reset-during-stall behaviour.
module tb_rv_instr_encoder;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  logic        rst1 = 1'b1;
  logic        clear1 = 1'b0;
  logic        in_valid1 = 1'b0;
  logic        in_ready1;
  logic        out_valid1;
  logic        out_ready1 = 1'b1;
  logic [31:0] out_instr1;
  logic [3:0]  out_addr1;
  logic        out_err1;
  logic [7:0]  err_count1;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [31:0] exp_addr = 32'h0;
  int   exp_cnt = 0;
  bit   rand_rdy = 1'b0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr;
  logic [31:0] prev_addr;
  logic        prev_err;

  always #5 clk = ~clk;

  rv_instr_encoder dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_count(err_count)
  );

  rv_instr_encoder #(.ADDR_W(4), .START_ADDR(4'hC), .ERR_CNT_W(8)) dut1 (
    .clk(clk), .rst(rst1), .clear(clear1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_instr(out_instr1), .out_addr(out_addr1), .out_err(out_err1),
    .err_count(err_count1)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: works on the immediate as a signed number and builds
  // the word with shifts and masks of the documented field positions.
  function automatic void ref_enc(input fields_t f, output logic [31:0] w, output bit e);
    logic [31:0] u;
    longint      si;
    u  = f.imm;
    si = longint'($signed(f.imm));
    w  = 32'h0;
    e  = 1'b0;
    case (f.fmt)
      3'd0: w = (32'(f.funct7) << 25) | (32'(f.rs2) << 20) | (32'(f.rs1) << 15) |
                (32'(f.funct3) << 12) | (32'(f.rd) << 7) | 32'(f.opcode);
      3'd1: begin
        w = ((u & 32'hFFF) << 20) | (32'(f.rs1) << 15) | (32'(f.funct3) << 12) |
            (32'(f.rd) << 7) | 32'(f.opcode);
        e = (si < -2048) || (si > 2047);
      end
      3'd2: begin
        w = (((u >> 5) & 32'h7F) << 25) | (32'(f.rs2) << 20) | (32'(f.rs1) << 15) |
            (32'(f.funct3) << 12) | ((u & 32'h1F) << 7) | 32'(f.opcode);
        e = (si < -2048) || (si > 2047);
      end
      3'd3: begin
        w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) |
            (32'(f.rs2) << 20) | (32'(f.rs1) << 15) | (32'(f.funct3) << 12) |
            (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | 32'(f.opcode);
        e = (si < -4096) || (si > 4095) || (si % 2 != 0);
      end
      3'd4: begin
        w = (u & 32'hFFFF_F000) | (32'(f.rd) << 7) | 32'(f.opcode);
        e = (u % 4096) != 0;
      end
      3'd5: begin
        w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
            (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) |
            (32'(f.rd) << 7) | 32'(f.opcode);
        e = (si < -(64'sd1 << 20)) || (si > (64'sd1 << 20) - 1) || (si % 2 != 0);
      end
      default: begin
        w = 32'h0;
        e = 1'b1;
      end
    endcase
  endfunction

  function automatic fields_t mk(logic [2:0] f, logic [6:0] op, logic [4:0] d,
                                 logic [4:0] s1, logic [4:0] s2, logic [2:0] f3,
                                 logic [31:0] im);
    fields_t r;
    r.fmt = f; r.opcode = op; r.rd = d; r.rs1 = s1; r.rs2 = s2;
    r.funct3 = f3; r.funct7 = 7'h20; r.imm = im;
    return r;
  endfunction

  function automatic fields_t rand_fields();
    fields_t r;
    r.fmt    = 3'($urandom_range(0, 7));
    r.opcode = 7'($urandom);
    r.rd     = 5'($urandom);
    r.rs1    = 5'($urandom);
    r.rs2    = 5'($urandom);
    r.funct3 = 3'($urandom);
    r.funct7 = 7'($urandom);
    case ($urandom_range(0, 3))
      0: r.imm = $urandom;
      1: r.imm = 32'($signed($urandom_range(0, 10000)) - 5000);
      2: r.imm = $urandom & 32'hFFFF_F000;
      default: r.imm = 32'($signed($urandom_range(0, 8)) - 4) + 32'(1 << ($urandom_range(10, 20)));
    endcase
    return r;
  endfunction

  // Presents one bundle until accepted; the expected word is queued at accept.
  task automatic send(input fields_t f, input bit has_exp, input logic [31:0] ew, input bit ee);
    exp_t        x;
    logic [31:0] w;
    bit          e;
    int          n;
    bit          ok;
    fmt = f.fmt; opcode = f.opcode; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2;
    funct3 = f.funct3; funct7 = f.funct7; imm = f.imm;
    in_valid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stuck at 0, expected 1 within 200 cycles");
    end else begin
      ref_enc(f, w, e);
      if (has_exp) begin
        w = ew;
        e = ee;
      end
      if (e && exp_cnt < 255) exp_cnt++;
      x.instr = w; x.addr = exp_addr; x.err = e; x.cnt = 8'(exp_cnt);
      sb.push_back(x);
      exp_addr = exp_addr + 32'd4;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: checks held words stay stable and pops the scoreboard on consume.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && out_valid) begin
        chk("stall_instr", out_instr, prev_instr);
        chk("stall_addr", out_addr, prev_addr);
        chk("stall_err", 32'(out_err), 32'(prev_err));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %h at %h, expected none", out_instr, out_addr);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("instr", out_instr, x.instr);
          chk("addr", out_addr, x.addr);
          chk("err", 32'(out_err), 32'(x.err));
          chk("err_count", 32'(err_count), 32'(x.cnt));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_addr  = out_addr;
      prev_err   = out_err;
    end
  end

  initial begin
    int t0;
    int k;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_err", 32'(out_err), 32'h0);
    chk("rst_addr", out_addr, 32'h0);
    chk("rst_cnt", 32'(err_count), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;

    // Known vectors.
    send(mk(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF), 1'b1, 32'hFFF0_0293, 1'b0);
    send(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC), 1'b1, 32'hFE20_8EE3, 1'b0);
    send(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048), 1'b1, 32'h0010_00EF, 1'b0);
    send(mk(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 32'h1234_5000), 1'b1, 32'h1234_50B7, 1'b0);
    send(mk(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 32'h1234_5001), 1'b1, 32'h1234_50B7, 1'b1);
    send(mk(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd2048), 1'b1, 32'h8000_0013, 1'b1);
    send(mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3), 1'b1, 32'h0000_0163, 1'b1);
    send(mk(3'd7, 7'h13, 5'd3, 5'd4, 5'd5, 3'd1, 32'd0), 1'b1, 32'h0000_0000, 1'b1);

    // Backpressure: second bundle waits while the first is held.
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(rand_fields(), 1'b0, 32'h0, 1'b0);
    fork
      send(rand_fields(), 1'b0, 32'h0, 1'b0);
      begin
        repeat (2) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(in_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join

    // Random traffic with random consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
      send(rand_fields(), 1'b0, 32'h0, 1'b0);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full-throughput streaming.
    t0 = int'($time);
    for (int i = 0; i < 10; i++) send(rand_fields(), 1'b0, 32'h0, 1'b0);
    chk("throughput_cycles", 32'((int'($time) - t0) / 10), 32'd10);

    k = 0;
    while ((sb.size() != 0 || out_valid) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);

    // Narrow-address instance: wrap, clear during stall, reset during stall.
    fmt = 3'd1; opcode = 7'h13; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("w_addr0", 32'(out_addr1), 32'hC);
    chk("w_instr0", out_instr1, 32'h0000_0093);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("w_addr1", 32'(out_addr1), 32'h0);
    fmt = 3'd7;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    out_ready1 = 1'b0;
    @(negedge clk);
    chk("w_ill_instr", out_instr1, 32'h0);
    chk("w_ill_err", 32'(out_err1), 32'h1);
    chk("w_ill_cnt", 32'(err_count1), 32'h1);
    @(posedge clk);
    #1;
    clear1 = 1'b1;
    @(posedge clk);
    #1;
    clear1 = 1'b0;
    @(negedge clk);
    chk("clr_valid", 32'(out_valid1), 32'h0);
    chk("clr_cnt", 32'(err_count1), 32'h0);
    fmt = 3'd1;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("clr_next_addr", 32'(out_addr1), 32'hC);
    chk("clr_next_valid", 32'(out_valid1), 32'h1);
    @(posedge clk);
    #3;
    rst1 = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid1), 32'h0);
    chk("arst_instr", out_instr1, 32'h0);
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    out_ready1 = 1'b1;
    clear1 = 1'b1;
    in_valid1 = 1'b1;
    @(negedge clk);
    chk("clr_acc_in_ready", 32'(in_ready1), 32'h1);
    @(posedge clk);
    #1;
    clear1 = 1'b0;
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("clr_acc_valid", 32'(out_valid1), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
